// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing a single I2C master among NREQ requesters.
// Optional: define I2C_ARB_TIMEOUT_EN to bound the transfer phase to TIMEOUT_CYC cycles.
module i2c_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WAIT_CYC    = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_stop,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              mst_start,
  output logic              mst_stop,
  output logic              mst_rw,
  output logic [6:0]        mst_addr,
  output logic [7:0]        mst_w_data,
  input  logic              mst_busy,
  output logic              arb_busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CNT_MAX = (WAIT_CYC > TIMEOUT_CYC) ? WAIT_CYC : TIMEOUT_CYC;
`else
  localparam int unsigned CNT_MAX = WAIT_CYC;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  // Reject out-of-range configurations at elaboration.
  if (NREQ < 2 || NREQ > 8 || WAIT_CYC < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("i2c_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_BUSY,
    S_XFER,
    S_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0]    gnt_d, done_d, err_d;
  logic               start_d, stop_d, rw_d, busy_d;
  logic [6:0]         addr_d;
  logic [7:0]         wdata_d;

  logic               rr_hit;
  logic [IDX_W-1:0]   rr_win;
  logic               sel_rw, sel_stop;
  logic [6:0]         sel_addr;
  logic [7:0]         sel_wdata;

  // Round-robin search: first active request at or after ptr+1, wrapping.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand   = '0;
    rr_hit = 1'b0;
    rr_win = ptr_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NREQ);
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_win = cand;
      end
    end
  end

  // Winner's request fields, captured only at grant time.
  always_comb begin
    sel_rw    = 1'b0;
    sel_stop  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rr_win == IDX_W'(i)) begin
        sel_rw    = req_rw[i];
        sel_stop  = req_stop[i];
        sel_addr  = req_addr[7*i +: 7];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic; the wait window counts from the mst_start cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    stop_d  = mst_stop;
    rw_d    = mst_rw;
    addr_d  = mst_addr;
    wdata_d = mst_w_data;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rr_hit && !mst_busy) begin
          win_d   = rr_win;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << rr_win;
          rw_d    = sel_rw;
          stop_d  = sel_stop;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          start_d = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (mst_busy) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end else if (cnt_q >= CNT_W'(WAIT_CYC - 1)) begin
          err_d   = gnt;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_XFER: begin
        if (!mst_busy) begin
          done_d  = gnt;
          state_d = S_RELEASE;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = gnt;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RELEASE: begin
        gnt_d   = '0;
        ptr_d   = win_q;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= IDX_W'(NREQ - 1);
      win_q      <= '0;
      cnt_q      <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= '0;
      mst_start  <= 1'b0;
      mst_stop   <= 1'b0;
      mst_rw     <= 1'b0;
      mst_addr   <= '0;
      mst_w_data <= '0;
      arb_busy   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt        <= gnt_d;
      done       <= done_d;
      err        <= err_d;
      mst_start  <= start_d;
      mst_stop   <= stop_d;
      mst_rw     <= rw_d;
      mst_addr   <= addr_d;
      mst_w_data <= wdata_d;
      arb_busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-timing reference model.
module tb_i2c_arbiter;

  localparam int NREQ     = 4;
  localparam int WAIT_CYC = 16;
  localparam int TO_CYC   = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, req_rw, req_stop;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, done, err;
  logic              mst_start, mst_stop, mst_rw, arb_busy, mst_busy;
  logic [6:0]        mst_addr;
  logic [7:0]        mst_w_data;

  logic mmode, man_busy, auto_busy;
  assign mst_busy = mmode ? man_busy : auto_busy;

  int errors = 0;
  int checks = 0;

  i2c_arbiter #(.NREQ(NREQ), .WAIT_CYC(WAIT_CYC), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(rst_n),
    .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_stop(req_stop),
    .gnt(gnt), .done(done), .err(err),
    .mst_start(mst_start), .mst_stop(mst_stop), .mst_rw(mst_rw),
    .mst_addr(mst_addr), .mst_w_data(mst_w_data),
    .mst_busy(mst_busy), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model: owner, cycles since start, and whether busy has been seen.
  int         m_own, m_age, m_xt, m_ptr;
  bit         m_up, m_end, m_ok;
  logic       m_rw, m_stop;
  logic [6:0] m_addr;
  logic [7:0] m_wd;

  function automatic void m_reset();
    m_own = -1; m_age = 0; m_xt = 0; m_ptr = NREQ - 1;
    m_up = 0; m_end = 0; m_ok = 0;
    m_rw = 0; m_stop = 0; m_addr = '0; m_wd = '0;
  endfunction

  function automatic void m_step();
    if (m_own >= 0) begin
      if (m_end) begin
        m_ptr = m_own; m_own = -1; m_end = 0;
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (!m_up) begin
        if (mst_busy) begin m_up = 1; m_xt = 0; end
        else if (m_age >= WAIT_CYC - 1) begin m_end = 1; m_ok = 0; end
        else m_age++;
      end else begin
        if (!mst_busy) begin m_end = 1; m_ok = 1; end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (m_xt >= TO_CYC - 1) begin m_end = 1; m_ok = 0; end
`endif
        else m_xt++;
      end
    end else if (req != '0 && !mst_busy) begin
      for (int j = 1; j <= NREQ; j++) begin
        int k;
        k = (m_ptr + j) % NREQ;
        if (m_own < 0 && req[k]) m_own = k;
      end
      m_rw   = req_rw[m_own];
      m_stop = req_stop[m_own];
      m_addr = req_addr[7*m_own +: 7];
      m_wd   = req_wdata[8*m_own +: 8];
      m_age = 0; m_up = 0; m_end = 0;
    end
  endfunction

  // Per-cycle compare at the falling edge, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    logic [NREQ-1:0] e_gnt;
    if (!rst_n) m_reset();
    e_gnt = (m_own >= 0) ? NREQ'(1 << m_own) : '0;
    chk("cyc_gnt", gnt, e_gnt);
    chk("cyc_gnt_onehot0", $onehot0(gnt), 1);
    chk("cyc_start", mst_start, (m_own >= 0 && m_age == 0 && !m_end));
    chk("cyc_done", done, (m_end && m_ok) ? e_gnt : '0);
    chk("cyc_err", err, (m_end && !m_ok) ? e_gnt : '0);
    chk("cyc_arb_busy", arb_busy, (m_own >= 0));
    chk("cyc_addr", mst_addr, m_addr);
    chk("cyc_wdata", mst_w_data, m_wd);
    chk("cyc_rw", mst_rw, m_rw);
    chk("cyc_stop", mst_stop, m_stop);
    if (rst_n) m_step();
  end

  // Random master: raises busy after a random delay for a random length.
  initial begin
    int d, len;
    auto_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!mmode && rst_n && mst_start) begin
        d   = $urandom_range(1, WAIT_CYC + 3);
        len = $urandom_range(1, 24);
        repeat (d) @(posedge clk);
        #1 auto_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 auto_busy = 1'b0;
      end
    end
  end

  task automatic rand_fields();
    req_rw    = NREQ'($urandom);
    req_stop  = NREQ'($urandom);
    req_addr  = (7*NREQ)'($urandom);
    req_wdata = (8*NREQ)'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (arb_busy !== 1'b0 && n < budget) begin step(); n++; end
    chk("idle_reached", arb_busy, 0);
  endtask

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    int bad, starts, n;
    rst_n = 1'b0; mmode = 1'b1; man_busy = 1'b0;
    req = '0; rand_fields();
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_addr", mst_addr, 0);
    chk("rst_wdata", mst_w_data, 0);
    rst_n = 1'b1;
    step();

    // Single write from requester 2 with a 20-cycle busy window.
    req = 4'b0100;
    req_addr[14 +: 7] = 7'h50; req_wdata[16 +: 8] = 8'hA5;
    req_rw[2] = 1'b0; req_stop[2] = 1'b1;
    step();
    chk("w_gnt", gnt, 4'b0100);
    chk("w_start", mst_start, 1);
    chk("w_addr", mst_addr, 7'h50);
    chk("w_wdata", mst_w_data, 8'hA5);
    chk("w_stop", mst_stop, 1);
    chk("w_rw", mst_rw, 0);
    req = '0;
    step();
    chk("w_start_once", mst_start, 0);
    man_busy = 1'b1;
    bad = 0; starts = 0;
    repeat (20) begin
      step();
      if (done !== '0) bad++;
      if (mst_start) starts++;
    end
    chk("w_no_early_done", bad, 0);
    chk("w_no_restart", starts, 0);
    man_busy = 1'b0;
    step();
    chk("w_done", done, 4'b0100);
    chk("w_no_err", err, 0);
    step();
    chk("w_done_pulse", done, 0);
    chk("w_gnt_released", gnt, 0);

    // Address change during transfer must not reach the master.
    req = 4'b0001; req_addr[0 +: 7] = 7'h50;
    step();
    chk("hold_gnt", gnt, 4'b0001);
    req = '0;
    step();
    man_busy = 1'b1;
    step();
    req_addr[0 +: 7] = 7'h51;
    bad = 0;
    repeat (5) begin step(); if (mst_addr !== 7'h50) bad++; end
    chk("hold_addr", bad, 0);
    man_busy = 1'b0;
    step();
    chk("hold_done", done, 4'b0001);
    chk("hold_addr_end", mst_addr, 7'h50);
    step();

    // Master never responds: err after WAIT_CYC cycles counted from mst_start.
    req = 4'b0010;
    step();
    chk("nb_start", mst_start, 1);
    req = '0;
    bad = 0;
    repeat (WAIT_CYC - 1) begin step(); if (err !== '0 || done !== '0) bad++; end
    chk("nb_quiet", bad, 0);
    step();
    chk("nb_err", err, 4'b0010);
    chk("nb_no_done", done, 0);
    step();
    chk("nb_released", gnt, 0);

    // Busy stuck high during transfer.
    req = 4'b1000;
    step();
    chk("stuck_gnt0", gnt, 4'b1000);
    req = '0;
    step();
    man_busy = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
    n = 0;
    while (err === '0 && n < 200) begin step(); n++; end
    chk("to_err_cycle", n, 65);
    chk("to_err", err, 4'b1000);
    man_busy = 1'b0;
    step();
`else
    repeat (3 * TO_CYC) step();
    chk("stuck_arb_busy", arb_busy, 1);
    chk("stuck_gnt", gnt, 4'b1000);
    chk("stuck_no_err", err, 0);
    man_busy = 1'b0;
    step();
    chk("stuck_done", done, 4'b1000);
`endif
    wait_idle(50);

    // Reset in the middle of a transfer.
    req = 4'b0001;
    req_addr[0 +: 7] = 7'h2A; req_wdata[0 +: 8] = 8'h3C; req_rw[0] = 1'b1; req_stop[0] = 1'b1;
    step();
    chk("mr_gnt", gnt, 4'b0001);
    req = '0;
    step();
    man_busy = 1'b1;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mr_gnt0", gnt, 0);
    chk("mr_done0", done, 0);
    chk("mr_err0", err, 0);
    chk("mr_start0", mst_start, 0);
    chk("mr_stop0", mst_stop, 0);
    chk("mr_rw0", mst_rw, 0);
    chk("mr_addr0", mst_addr, 0);
    chk("mr_wdata0", mst_w_data, 0);
    chk("mr_busy0", arb_busy, 0);
    step();
    rst_n = 1'b1; man_busy = 1'b0; req = 4'b1010;
    step();
    chk("mr_first_gnt", gnt, 4'b0010);
    req = '0;
    wait_idle(60);

    // Fresh reset, then all requesters held: strict rotation from requester 0.
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1; mmode = 1'b0; req = '1;
    for (int t = 0; t < 8; t++) begin
      n = 0;
      @(negedge clk);
      while (mst_start !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      chk("rr_start_seen", mst_start, 1);
      chk("rr_order", oh_idx(gnt), exp_order[t]);
    end

    // Randomized traffic against the model.
    step();
    for (int it = 0; it < 150; it++) begin
      req = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      rand_fields();
      repeat ($urandom_range(1, 30)) step();
    end
    req = '0;
    repeat (120) step();
    wait_idle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
